// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: shifts MOSI/MISO on spi_clk_gen strobes.
// Optional done interrupt enabled by defining SPI_XFER_IRQ_EN.
module spi_xfer_ctrl #(
    parameter int MAX_CHAR = 32,
    parameter int CNT_W    = 5,
    parameter int SS_NB    = 8
) (
    input  logic                wb_clk_in,
    input  logic                wb_rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    char_len,
    input  logic                lsb,
    input  logic                tx_negedge,
    input  logic                rx_negedge,
    input  logic                auto_ss,
    input  logic [SS_NB-1:0]    ss_sel,
    input  logic [MAX_CHAR-1:0] tx_data,
    input  logic                cpol_0,
    input  logic                cpol_1,
    input  logic                miso,
    output logic                go,
    output logic                tip,
    output logic                mosi,
    output logic [SS_NB-1:0]    ss_pad_o,
    output logic [MAX_CHAR-1:0] rx_data,
    output logic                done
`ifdef SPI_XFER_IRQ_EN
    ,
    input  logic                irq_en,
    input  logic                irq_ack,
    output logic                irq
`endif
);

    localparam int CW = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       txrem_q, txrem_d;
    logic [CW-1:0]       len_q, len_d;
    logic [CNT_W-1:0]    txidx_q, txidx_d;
    logic                lsb_q, lsb_d;
    logic                txneg_q, txneg_d;
    logic                rxneg_q, rxneg_d;
    logic [MAX_CHAR-1:0] txd_q, txd_d;
    logic                mosi_q, mosi_d;
    logic [MAX_CHAR-1:0] rx_q, rx_d;
    logic [SS_NB-1:0]    ss_q, ss_d;

    logic [CW-1:0]       len_in;
    logic [CW-1:0]       len_m1;
    logic [CNT_W-1:0]    first_idx;
    logic [CW-1:0]       rx_pos;
    logic [CNT_W-1:0]    rxidx;
    logic [CNT_W-1:0]    txidx_n;
    logic                tx_edge;
    logic                rx_edge;

    // char_len of zero stands for a full MAX_CHAR-bit character
    assign len_in    = (char_len == '0) ? CW'(MAX_CHAR) : {1'b0, char_len};
    assign len_m1    = len_in - CW'(1);
    assign first_idx = lsb ? '0 : len_m1[CNT_W-1:0];

    assign rx_pos  = lsb_q ? (len_q - cnt_q) : (cnt_q - CW'(1));
    assign rxidx   = rx_pos[CNT_W-1:0];
    assign txidx_n = lsb_q ? (txidx_q + CNT_W'(1)) : (txidx_q - CNT_W'(1));

    assign tx_edge = txneg_q ? cpol_1 : cpol_0;
    assign rx_edge = rxneg_q ? cpol_1 : cpol_0;

    assign go       = (state_q == SHIFT);
    assign tip      = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign mosi     = mosi_q;
    assign rx_data  = rx_q;
    assign ss_pad_o = ss_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        txrem_d = txrem_q;
        len_d   = len_q;
        txidx_d = txidx_q;
        lsb_d   = lsb_q;
        txneg_d = txneg_q;
        rxneg_d = rxneg_q;
        txd_d   = txd_q;
        mosi_d  = mosi_q;
        rx_d    = rx_q;
        ss_d    = auto_ss ? ~(ss_sel & {SS_NB{tip}}) : ~ss_sel;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = len_in;
                    txrem_d = len_in;
                    len_d   = len_in;
                    lsb_d   = lsb;
                    txneg_d = tx_negedge;
                    rxneg_d = rx_negedge;
                    txd_d   = tx_data;
                    txidx_d = first_idx;
                    mosi_d  = tx_data[first_idx];
                    rx_d    = '0;
                end
            end
            SHIFT: begin
                if (tx_edge && (txrem_q > CW'(1))) begin
                    txidx_d = txidx_n;
                    mosi_d  = txd_q[txidx_n];
                    txrem_d = txrem_q - CW'(1);
                end
                // rx index is derived from the pre-decrement count
                if (rx_edge) begin
                    rx_d[rxidx] = miso;
                    cnt_d       = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_in or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            txrem_q <= '0;
            len_q   <= '0;
            txidx_q <= '0;
            lsb_q   <= 1'b0;
            txneg_q <= 1'b0;
            rxneg_q <= 1'b0;
            txd_q   <= '0;
            mosi_q  <= 1'b0;
            rx_q    <= '0;
            ss_q    <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txrem_q <= txrem_d;
            len_q   <= len_d;
            txidx_q <= txidx_d;
            lsb_q   <= lsb_d;
            txneg_q <= txneg_d;
            rxneg_q <= rxneg_d;
            txd_q   <= txd_d;
            mosi_q  <= mosi_d;
            rx_q    <= rx_d;
            ss_q    <= ss_d;
        end
    end

`ifdef SPI_XFER_IRQ_EN
    logic irq_q, irq_d;

    // a new done outranks a concurrent acknowledge
    always_comb begin
        irq_d = irq_q;
        if (done && irq_en) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_in or negedge wb_rst) begin
        if (!wb_rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule
